clkdiv_gate: RTL and testbench



---
 rtl/clkdiv_gate_pkg.sv | 13 +
 rtl/clkdiv_gate_cnt.sv | 28 ++
 rtl/clkdiv_gate.sv | 114 +++++++++++
 tb/tb_clkdiv_gate.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/clkdiv_gate_pkg.sv
// clkdiv_gate_pkg: shared types and defaults for the clkdiv_gate divider.
// State encoding and default DIV width.
package clkdiv_gate_pkg;

    localparam int CLKDIV_DIV_W = 4;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } st_e;

endpackage

// File: rtl/clkdiv_gate_cnt.sv
// clkdiv_gate_cnt: phase counter with sync clear, increment enable
// and terminal-count compare against the latched ratio.
module clkdiv_gate_cnt
    import clkdiv_gate_pkg::*;
#(
    parameter int DIV_W = CLKDIV_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_tc
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_ratio);

endmodule

// File: rtl/clkdiv_gate.sv
// clkdiv_gate: glitch-free programmable clock divider and gate.
// Optional macro CLKDIV_GATE_TEST_BYPASS_EN adds TE (Z = CLK bypass).
module clkdiv_gate
    import clkdiv_gate_pkg::*;
#(
    parameter int DIV_W = CLKDIV_DIV_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
`ifdef CLKDIV_GATE_TEST_BYPASS_EN
    input  logic             TE,
`endif
    input  logic [DIV_W-1:0] DIV,
    output logic             Z,
    output logic             ACK,
    inout  wire              VDD,
    inout  wire              VSS
);

    st_e              r_st;
    st_e              w_st_n;
    logic [DIV_W-1:0] r_ratio;
    logic [DIV_W-1:0] w_ratio_n;
    logic             r_z;
    logic             w_z_n;
    logic             r_ack;
    logic             w_ack_n;
    logic             w_tc;
    logic             w_clr;
    logic             w_inc;
    logic             w_unused_pwr;

    assign w_unused_pwr = VDD ^ VSS;

    clkdiv_gate_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_ratio (r_ratio),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_st_n    = r_st;
        w_ratio_n = r_ratio;
        w_z_n     = r_z;
        w_ack_n   = r_ack;
        w_clr     = 1'b0;
        w_inc     = 1'b0;
        unique case (r_st)
            OFF: begin
                if (EN) begin
                    w_st_n    = RUN;
                    w_z_n     = 1'b1;
                    w_ack_n   = 1'b1;
                    w_clr     = 1'b1;
                    w_ratio_n = DIV;
                end
            end
            RUN, DRAIN: begin
                // Stop only after a complete low phase
                if (r_st == DRAIN && !EN && w_tc && !r_z) begin
                    w_st_n  = OFF;
                    w_ack_n = 1'b0;
                    w_clr   = 1'b1;
                end else begin
                    w_st_n = EN ? RUN : DRAIN;
                    if (w_tc) begin
                        w_clr = 1'b1;
                        w_z_n = ~r_z;
                        if (!r_z) begin
                            w_ratio_n = DIV;
                        end
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_st_n  = OFF;
                w_clr   = 1'b1;
                w_z_n   = 1'b0;
                w_ack_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_st    <= OFF;
            r_ratio <= '0;
            r_z     <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_st    <= w_st_n;
            r_ratio <= w_ratio_n;
            r_z     <= w_z_n;
            r_ack   <= w_ack_n;
        end
    end

`ifdef CLKDIV_GATE_TEST_BYPASS_EN
    assign Z   = TE ? CLK : r_z;
    assign ACK = TE | r_ack;
`else
    assign Z   = r_z;
    assign ACK = r_ack;
`endif

endmodule

// File: tb/tb_clkdiv_gate.sv
// tb_clkdiv_gate: directed and random stimulus against a phase-length
// reference model of the divider.
module tb_clkdiv_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] div = 4'd0;
    logic       z;
    logic       ack;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;
`ifdef CLKDIV_GATE_TEST_BYPASS_EN
    logic       te  = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // reference: on/level, cycles left in current phase, latched ratio
    bit m_on;
    bit m_lvl;
    bit m_ack;
    bit m_drain;
    int m_rem;
    int m_ratio;

    always #5 clk = ~clk;

    clkdiv_gate #(
        .DIV_W (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .EN  (en),
`ifdef CLKDIV_GATE_TEST_BYPASS_EN
        .TE  (te),
`endif
        .DIV (div),
        .Z   (z),
        .ACK (ack),
        .VDD (vdd),
        .VSS (vss)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model(input bit r, input bit e, input int d);
        if (r) begin
            m_on = 0; m_lvl = 0; m_ack = 0;
            m_drain = 0; m_rem = 0; m_ratio = 0;
        end else if (!m_on) begin
            if (e) begin
                m_on = 1; m_lvl = 1; m_ack = 1; m_drain = 0;
                m_ratio = d; m_rem = d + 1;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (!m_lvl && !e && m_drain) begin
                    m_on = 0; m_ack = 0;
                end else begin
                    m_lvl = !m_lvl;
                    if (m_lvl) m_ratio = d;
                    m_rem = m_ratio + 1;
                end
            end
            m_drain = !e;
        end
    endtask

    task automatic step(input bit r, input bit e, input int d, input string tag);
        @(negedge clk);
        rst = r; en = e; div = d[3:0];
        @(posedge clk);
        model(r, e, d);
        #1;
        chk({tag, ".z"}, int'(z), int'(m_lvl));
        chk({tag, ".ack"}, int'(ack), int'(m_ack));
    endtask

    initial begin
        logic [11:0] pat;
        int d;
        bit e;
        bit r;
        model(1'b1, 1'b0, 0);

        repeat (3) step(1, 1, 2, "rst");
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 2, "div2");
            pat = {pat[10:0], z};
        end
        chk("pat_div2", int'(pat), int'(12'b111000111000));

        repeat (6) step(0, 1, 0, "div0");
        repeat (5) step(0, 1, 2, "pre5");
        repeat (24) step(0, 1, 5, "div5");
        repeat (4) step(0, 1, 2, "back2");
        step(0, 1, 6, "pulse");
        repeat (12) step(0, 1, 2, "post");

        repeat (20) step(0, 1, 3, "run3");
        repeat (14) step(0, 0, 3, "stop");
        chk("off_z", int'(z), 0);
        chk("off_ack", int'(ack), 0);

        repeat (9) step(0, 1, 3, "res");
        repeat (3) step(0, 0, 3, "drop");
        repeat (12) step(0, 1, 3, "again");

        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 85);
            d = $urandom_range(0, 15);
            if (i % 40 < 25) d = 1;
            step(r, e, d, "rnd");
        end

`ifdef CLKDIV_GATE_TEST_BYPASS_EN
        @(negedge clk);
        te = 1'b1;
        @(posedge clk);
        model(0, en, int'(div));
        #1;
        chk("te_hi", int'(z), 1);
        chk("te_ack", int'(ack), 1);
        @(negedge clk);
        #1;
        chk("te_lo", int'(z), 0);
        te = 1'b0;
        @(posedge clk);
        model(0, en, int'(div));
        #1;
        chk("te_off", int'(z), int'(m_lvl));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
